// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-port memory arbiter: FSM encodings, port ids,
// request record layout and the request-validity helper.
package mem_arb_defs;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic logic req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection for mem_arbiter: request validity, grant_now, the starvation
// counter (or last-grant register when MEM_ARB_RR_EN is defined) and proto_err.
module mem_arb_select
    import mem_arb_defs::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rd,
    input  logic i_wr,
    input  logic d_rd,
    input  logic d_wr,
    input  logic arb_en,
    output logic grant_issue,
    output logic grant_now,
    output logic proto_err
);

    logic       i_valid;
    logic       d_valid;
    logic [3:0] wait_cnt;

    assign i_valid     = req_valid(i_rd, i_wr);
    assign d_valid     = req_valid(d_rd, d_wr);
    assign grant_issue = arb_en & (i_valid | d_valid);

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    assign wait_cnt = 4'd0;

    // With both ports valid, the port that did not win last time goes next.
    always_comb begin
        grant_now = PORT_I;
        if (i_valid && d_valid) begin
            grant_now = ~last_grant;
        end else if (d_valid) begin
            grant_now = PORT_D;
        end else begin
            grant_now = PORT_I;
        end
    end

    // Remember the most recent winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_D;
        end else if (grant_issue) begin
            last_grant <= grant_now;
        end else begin
            last_grant <= last_grant;
        end
    end
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // D has priority unless I has lost MAX_WAIT arbitrations in a row.
    always_comb begin
        grant_now = PORT_I;
        if (d_valid && !(i_valid && (wait_cnt >= MAX_WAIT_C))) begin
            grant_now = PORT_D;
        end else begin
            grant_now = PORT_I;
        end
    end

    // Count D wins against a waiting I; saturates so it can never wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (!i_valid) begin
            wait_cnt <= 4'd0;
        end else if (grant_issue && (grant_now == PORT_I)) begin
            wait_cnt <= 4'd0;
        end else if (grant_issue) begin
            wait_cnt <= (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
        end else begin
            wait_cnt <= wait_cnt;
        end
    end
`endif

    // Sticky flag for a requester driving rd and wr together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if ((i_rd & i_wr) | (d_rd & d_wr)) begin
            proto_err <= 1'b1;
        end else begin
            proto_err <= proto_err;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I/D) arbiter in front of a single mem_system. Optional round-robin
// arbitration is enabled with the MEM_ARB_RR_EN macro.
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_done,
    output logic              i_hit,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_done,
    output logic              d_hit,
    output logic              d_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_hit,
    output logic              proto_err
);

    logic [0:0] state;
    logic       grant_q;
    req_t       req_q;

    logic       arb_en;
    logic       grant_issue;
    logic       grant_now;
    req_t       i_req;
    req_t       d_req;
    req_t       win_req;
    req_t       cur_req;
    logic       cur_port;
    logic       active;
    logic       fin;

    assign i_req   = '{rd: i_rd, wr: i_wr, addr: i_addr, data: i_data_in};
    assign d_req   = '{rd: d_rd, wr: d_wr, addr: d_addr, data: d_data_in};
    // rst gates arbitration so every output sits at its reset value while rst is high.
    assign arb_en  = (state == ST_IDLE) && !mem_stall && !rst;
    assign win_req = (grant_now == PORT_D) ? d_req : i_req;

    mem_arb_select #(
        .MAX_WAIT(MAX_WAIT)
    ) u_select (
        .clk        (clk),
        .rst        (rst),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .arb_en     (arb_en),
        .grant_issue(grant_issue),
        .grant_now  (grant_now),
        .proto_err  (proto_err)
    );

    // Current owner of the memory: latched request when busy, live winner otherwise.
    always_comb begin
        cur_req  = '0;
        cur_port = PORT_I;
        active   = 1'b0;
        if (state == ST_BUSY) begin
            cur_req  = req_q;
            cur_port = grant_q;
            active   = 1'b1;
        end else if (grant_issue) begin
            cur_req  = win_req;
            cur_port = grant_now;
            active   = 1'b1;
        end else begin
            cur_req  = '0;
            cur_port = PORT_I;
            active   = 1'b0;
        end
    end

    assign fin         = active & mem_done;
    assign mem_rd      = cur_req.rd;
    assign mem_wr      = cur_req.wr;
    assign mem_addr    = cur_req.addr;
    assign mem_data_in = cur_req.data;

    assign i_stall    = ~(active && (cur_port == PORT_I));
    assign d_stall    = ~(active && (cur_port == PORT_D));
    assign i_done     = fin && (cur_port == PORT_I);
    assign d_done     = fin && (cur_port == PORT_D);
    assign i_hit      = i_done & mem_hit;
    assign d_hit      = d_done & mem_hit;
    assign i_data_out = i_done ? mem_data_out : 16'h0000;
    assign d_data_out = d_done ? mem_data_out : 16'h0000;

    // IDLE/BUSY sequencing; a grant completed in its own cycle never enters BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= PORT_D;
            req_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_issue) begin
                        grant_q <= grant_now;
                        req_q   <= win_req;
                        state   <= mem_done ? ST_IDLE : ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_done) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_BUSY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a mem_system stand-in plus a
// transaction-level reference model checked every cycle, and directed scenarios.
module tb_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_rd = 1'b0, i_wr = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = 16'h0, i_data_in = 16'h0, d_addr = 16'h0, d_data_in = 16'h0;
    logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in;
    logic        i_done, i_hit, i_stall, d_done, d_hit, d_stall;
    logic        mem_rd, mem_wr, proto_err;
    logic [15:0] mem_data_out = 16'h0;
    logic        mem_done = 1'b0, mem_stall = 1'b0, mem_hit = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_data_out(i_data_out), .i_done(i_done), .i_hit(i_hit), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_done(d_done), .d_hit(d_hit), .d_stall(d_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_hit(mem_hit), .proto_err(proto_err)
    );

    // mem_system stand-in storage and the reference model's own copy
    logic [15:0] mem_arr [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit sa_active;
    int sa_rem;
    bit sa_hit;
    int fixed_lat = -1;

    // reference model state
    bit m_busy, m_owner, m_rd, m_wr, m_proto, m_last;
    logic [15:0] m_addr, m_data;
    int m_wait;

    // expectations and observations of the last stepped cycle
    bit e_i_done, e_d_done;
    logic o_i_stall, o_d_stall, o_i_done, o_d_done, o_mem_rd;
    logic [15:0] o_mem_addr, o_i_data, o_d_data;

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_proto = 1'b0;
        m_last = 1'b1; m_addr = 16'h0; m_data = 16'h0; m_wait = 0;
        sa_active = 1'b0; sa_rem = 0;
        mem_done = 1'b0; mem_hit = 1'b0; mem_data_out = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_i();
        i_rd = 1'b0; i_wr = 1'b0;
    endtask

    task automatic clear_d();
        d_rd = 1'b0; d_wr = 1'b0;
    endtask

    // One clock cycle: called at posedge+1 with requester inputs set; returns at next posedge+1.
    task automatic step();
        bit iv, dv, grant, win, was_busy, crd, cwr;
        logic [15:0] caddr, cdata, edata;
        logic [8:0] exp_ctrl, got_ctrl;
        #1;
        mem_done = 1'b0; mem_hit = 1'b0; mem_data_out = 16'h0;
        if (mem_rd | mem_wr) begin
            if (!sa_active) begin
                sa_active = 1'b1;
                sa_rem = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                sa_hit = (sa_rem == 0);
            end
            if (sa_rem == 0) begin
                mem_done = 1'b1;
                mem_hit = sa_hit;
                if (mem_rd) mem_data_out = mem_arr[mem_addr];
                else mem_arr[mem_addr] = mem_data_in;
                sa_active = 1'b0;
            end else begin
                sa_rem--;
            end
        end
        #1;
        iv = i_rd ^ i_wr;
        dv = d_rd ^ d_wr;
        was_busy = m_busy;
        grant = 1'b0; win = 1'b1; crd = 1'b0; cwr = 1'b0; caddr = 16'h0; cdata = 16'h0;
        if (m_busy) begin
            grant = 1'b1; win = m_owner;
            crd = m_rd; cwr = m_wr; caddr = m_addr; cdata = m_data;
        end else if (!mem_stall && (iv || dv)) begin
            grant = 1'b1;
`ifdef MEM_ARB_RR_EN
            win = (iv && dv) ? ~m_last : dv;
`else
            win = dv && !(iv && (m_wait >= MAX_WAIT));
`endif
            if (win) begin crd = d_rd; cwr = d_wr; caddr = d_addr; cdata = d_data_in; end
            else begin crd = i_rd; cwr = i_wr; caddr = i_addr; cdata = i_data_in; end
        end
        e_i_done = grant && mem_done && !win;
        e_d_done = grant && mem_done && win;
        edata = crd ? ref_mem[caddr] : 16'h0;
        exp_ctrl = {crd, cwr, !(grant && !win), !(grant && win), e_i_done, e_d_done,
                    e_i_done & mem_hit, e_d_done & mem_hit, m_proto};
        got_ctrl = {mem_rd, mem_wr, i_stall, d_stall, i_done, d_done, i_hit, d_hit, proto_err};
        checks++;
        if (got_ctrl !== exp_ctrl) begin
            failures++;
            $display("FAIL ctrl t=%0t {rd,wr,is,ds,id,dd,ih,dh,pe}: got %b expected %b", $time, got_ctrl, exp_ctrl);
        end
        checks++;
        if (i_data_out !== (e_i_done ? edata : 16'h0)) begin
            failures++;
            $display("FAIL i_data_out t=%0t: got %h expected %h", $time, i_data_out, e_i_done ? edata : 16'h0);
        end
        checks++;
        if (d_data_out !== (e_d_done ? edata : 16'h0)) begin
            failures++;
            $display("FAIL d_data_out t=%0t: got %h expected %h", $time, d_data_out, e_d_done ? edata : 16'h0);
        end
        if (grant) begin
            checks++;
            if ({mem_addr, mem_data_in} !== {caddr, cdata}) begin
                failures++;
                $display("FAIL mem_addr_data t=%0t: got %h/%h expected %h/%h", $time, mem_addr, mem_data_in, caddr, cdata);
            end
        end
        o_i_stall = i_stall; o_d_stall = d_stall; o_i_done = i_done; o_d_done = d_done;
        o_mem_rd = mem_rd; o_mem_addr = mem_addr; o_i_data = i_data_out; o_d_data = d_data_out;
        if (grant && mem_done && cwr) ref_mem[caddr] = cdata;
        if (!was_busy && grant) begin
            m_last = win;
            if (!mem_done) begin
                m_busy = 1'b1; m_owner = win; m_rd = crd; m_wr = cwr; m_addr = caddr; m_data = cdata;
            end
        end else if (was_busy && mem_done) begin
            m_busy = 1'b0;
        end
`ifndef MEM_ARB_RR_EN
        if (!iv) m_wait = 0;
        else if (!was_busy && grant) m_wait = win ? ((m_wait >= 15) ? 15 : m_wait + 1) : 0;
`endif
        m_proto = m_proto | (i_rd & i_wr) | (d_rd & d_wr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        i_rd = 1'b1; i_addr = 16'h0010; d_wr = 1'b1; d_addr = 16'h0040;
        mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hFFFF;
        #2;
        checks++;
        if ({mem_rd, mem_wr, i_stall, d_stall, i_done, d_done, i_hit, d_hit, proto_err} !== 9'b0_0_1_1_0_0_0_0_0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 001100000",
                     {mem_rd, mem_wr, i_stall, d_stall, i_done, d_done, i_hit, d_hit, proto_err});
        end
        checks++;
        if ({i_data_out, d_data_out} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {i_data_out, d_data_out});
        end
        checks++;
        if (dut.u_select.wait_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_wait_cnt: got %0d expected 0", dut.u_select.wait_cnt);
        end
        clear_i(); clear_d();
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_lone_read();
        int done_at, done_cnt, dstall_low;
        fixed_lat = 3;
        i_rd = 1'b1; i_addr = 16'h0010;
        done_at = -1; done_cnt = 0; dstall_low = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_d_stall === 1'b0) dstall_low++;
            if (o_i_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                clear_i();
            end
        end
        checks++;
        if (done_at != 3 || done_cnt != 1 || dstall_low != 0) begin
            failures++;
            $display("FAIL lone_read: got done_at=%0d pulses=%0d d_stall_low=%0d expected 3/1/0", done_at, done_cnt, dstall_low);
        end
        checks++;
        if (i_stall !== 1'b1 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL lone_read_idle: got i_stall=%b mem_rd=%b expected 1/0", i_stall, mem_rd);
        end
    endtask

    task automatic test_contention();
        bit i_fin, d_fin, first, chk_next;
        fixed_lat = -1;
        i_rd = 1'b1; i_addr = 16'h0020;
        d_wr = 1'b1; d_addr = 16'h0040; d_data_in = 16'hBEEF;
        i_fin = 1'b0; d_fin = 1'b0; first = 1'b1; chk_next = 1'b0;
        for (int k = 0; k < 30 && !(i_fin && d_fin); k++) begin
            step();
            if (first) begin
                checks++;
                if ({o_d_stall, o_i_stall} !== 2'b01) begin
                    failures++;
                    $display("FAIL contention_first: got d_stall,i_stall=%b expected 01", {o_d_stall, o_i_stall});
                end
                first = 1'b0;
            end
            if (chk_next) begin
                checks++;
                if ({o_i_stall, o_mem_rd, o_mem_addr} !== {1'b0, 1'b1, 16'h0020}) begin
                    failures++;
                    $display("FAIL contention_i_next: got i_stall=%b mem_rd=%b addr=%h expected 0/1/0020", o_i_stall, o_mem_rd, o_mem_addr);
                end
                chk_next = 1'b0;
            end
            if (o_d_done === 1'b1) begin d_fin = 1'b1; chk_next = 1'b1; clear_d(); end
            if (o_i_done === 1'b1) begin i_fin = 1'b1; clear_i(); end
        end
        checks++;
        if (!(i_fin && d_fin)) begin
            failures++;
            $display("FAIL contention_timeout: got i=%b d=%b expected both done", i_fin, d_fin);
        end
        d_rd = 1'b1; d_addr = 16'h0040;
        d_fin = 1'b0;
        for (int k = 0; k < 20 && !d_fin; k++) begin
            step();
            if (o_d_done === 1'b1) begin
                d_fin = 1'b1; clear_d();
                checks++;
                if (o_d_data !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL readback_0040: got %h expected beef", o_d_data);
                end
            end
        end
        checks++;
        if (!d_fin) begin
            failures++;
            $display("FAIL readback_timeout: got no d_done expected one");
        end
    endtask

    task automatic test_starvation();
        int dcnt;
        bit igr, idone;
        fixed_lat = 1;
        i_rd = 1'b1; i_addr = 16'h0030;
        d_rd = 1'b1; d_addr = 16'h0100;
        dcnt = 0; igr = 1'b0; idone = 1'b0;
        for (int k = 0; k < 80 && !idone; k++) begin
            step();
            if (o_i_stall === 1'b0 && !igr) begin
                igr = 1'b1;
                checks++;
                if (dcnt != MAX_WAIT || dut.u_select.wait_cnt !== 4'd0) begin
                    failures++;
                    $display("FAIL starvation_grant: got d_wins=%0d wait_cnt=%0d expected %0d/0", dcnt, dut.u_select.wait_cnt, MAX_WAIT);
                end
            end
            if (o_d_done === 1'b1) begin dcnt++; d_addr = d_addr + 16'h0001; end
            if (o_i_done === 1'b1) begin idone = 1'b1; clear_i(); end
        end
        clear_d();
        checks++;
        if (!idone) begin
            failures++;
            $display("FAIL starvation_timeout: got no i_done expected one");
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_d_done === 1'b1) clear_d();
        end
    endtask

    task automatic test_addr_hold();
        bit fin;
        fixed_lat = 3;
        d_rd = 1'b1; d_addr = 16'h0040;
        step();
        d_addr = 16'h0100;
        fin = 1'b0;
        for (int k = 0; k < 10 && !fin; k++) begin
            step();
            checks++;
            if (o_mem_addr !== 16'h0040) begin
                failures++;
                $display("FAIL addr_hold: got %h expected 0040", o_mem_addr);
            end
            if (o_d_done === 1'b1) begin
                fin = 1'b1; clear_d();
                checks++;
                if (o_d_data !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL addr_hold_data: got %h expected beef", o_d_data);
                end
            end
        end
    endtask

    task automatic test_proto();
        int ndone, igrant;
        fixed_lat = -1;
        i_rd = 1'b1; i_wr = 1'b1; i_addr = 16'h0050;
        ndone = 0; igrant = 0;
        d_rd = 1'b1; d_addr = 16'h0060;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            step();
            if (o_i_stall === 1'b0) igrant++;
            if (o_d_done === 1'b1) begin ndone++; d_addr = d_addr + 16'h0001; end
        end
        clear_d();
        checks++;
        if (proto_err !== 1'b1 || ndone != 3 || igrant != 0) begin
            failures++;
            $display("FAIL proto: got proto_err=%b d_done=%0d i_grants=%0d expected 1/3/0", proto_err, ndone, igrant);
        end
        clear_i();
        repeat (3) step();
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_sticky: got %b expected 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        fixed_lat = 5;
        d_rd = 1'b1; d_addr = 16'h0040;
        step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_rd, mem_wr, i_stall, d_stall, d_done, proto_err, d_data_out} !== {6'b001100, 16'h0}) begin
            failures++;
            $display("FAIL reset_mid: got %b/%h expected 001100/0000",
                     {mem_rd, mem_wr, i_stall, d_stall, d_done, proto_err}, d_data_out);
        end
        do_reset();
        fixed_lat = 2;
        fin = 1'b0;
        for (int k = 0; k < 10 && !fin; k++) begin
            step();
            if (o_d_done === 1'b1) begin
                fin = 1'b1; clear_d();
                checks++;
                if (o_d_data !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL reset_reissue: got %h expected beef", o_d_data);
                end
            end
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL reset_reissue_timeout: got no d_done expected one");
        end
    endtask

    task automatic test_random();
        fixed_lat = -1;
        for (int k = 0; k < 1500; k++) begin
            mem_stall = ($urandom_range(0, 9) == 0);
            step();
            if (o_i_done === 1'b1) clear_i();
            if (o_d_done === 1'b1) clear_d();
            if (!(i_rd | i_wr) && $urandom_range(0, 2) == 0) begin
                i_rd = $urandom_range(0, 1); i_wr = ~i_rd;
                i_addr = 16'($urandom_range(0, 63)); i_data_in = 16'($urandom);
            end
            if (!(d_rd | d_wr) && $urandom_range(0, 2) == 0) begin
                d_rd = $urandom_range(0, 1); d_wr = ~d_rd;
                d_addr = 16'($urandom_range(0, 63)); d_data_in = 16'($urandom);
            end
        end
        mem_stall = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem_arr[a] = 16'(a) ^ 16'h5A5A;
            ref_mem[a] = 16'(a) ^ 16'h5A5A;
        end
        model_reset();
        test_reset();
        test_lone_read();
        test_contention();
        test_starvation();
        test_addr_hold();
        test_proto();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
